lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_lane.sv | 44 ++++
 rtl/lsu.sv | 150 +++++++++++++++
 tb/tb_lsu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// default address width and the misalignment rule.
package lsu_pkg;

  localparam int unsigned byte_addr_p = 12;

  typedef enum logic [1:0] {
    LSU_B = 2'd0,
    LSU_H = 2'd1,
    LSU_W = 2'd2
  } t_lsu_size;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWait,
    StWr,
    StResp
  } t_lsu_state;

  function automatic logic lsu_misaligned(input t_lsu_size size, input logic [1:0] off);
    return ((size == LSU_H) && off[0]) || ((size == LSU_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [31:0] st_base_i,
  input  logic [31:0] st_data_i,
  input  t_lsu_size   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  off_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;

  always_comb begin
    ld_byte   = ld_word_i[{off_i, 3'b000} +: 8];
    ld_half   = ld_word_i[{off_i[1], 4'b0000} +: 16];
    sext      = ~unsigned_i;
    ld_data_o = ld_word_i;
    st_word_o = st_data_i;
    case (size_i)
      LSU_B: begin
        ld_data_o = {{24{sext & ld_byte[7]}}, ld_byte};
        st_word_o = st_base_i;
        st_word_o[{off_i, 3'b000} +: 8] = st_data_i[7:0];
      end
      LSU_H: begin
        // addr[0] is ignored: a misaligned half uses the lane picked by addr[1]
        ld_data_o = {{16{sext & ld_half[15]}}, ld_half};
        st_word_o = st_base_i;
        st_word_o[{off_i[1], 4'b0000} +: 16] = st_data_i[15:0];
      end
      default: begin
        ld_data_o = ld_word_i;
        st_word_o = st_data_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit in front of a word-wide RAM without byte enables.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned requests with an error response.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = byte_addr_p,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  t_lsu_size         req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned CntW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

  t_lsu_state        state_q, state_d;
  logic              we_q, we_d;
  t_lsu_size         size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        misal;

  lsu_lane u_lane (
    .ld_word_i  (mem_rdata_i),
    .st_base_i  (rdata_q),
    .st_data_i  (wdata_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (addr_q[1:0]),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      size_q      <= LSU_B;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    misal       = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = lsu_misaligned(req_size_i, req_addr_i[1:0]);
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (misal) begin
            state_d     = StResp;
            rsp_rdata_d = '0;
          end else if (req_we_i && (req_size_i == LSU_W)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: state_d = StWait;
      StWait: begin
        if (cnt_q == CntW'(MEM_LAT - 1)) begin
          rdata_d = mem_rdata_i;
          if (we_q) begin
            state_d = StWr;
          end else begin
            state_d     = StResp;
            rsp_rdata_d = ld_data;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWr: begin
        state_d     = StResp;
        rsp_rdata_d = '0;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are masked by rst_i so an abort never leaks a write or response
  assign req_ready_o = (state_q == StIdle) & ~rst_i;
  assign mem_rd_en_o = (state_q == StRd) & ~rst_i;
  assign mem_wr_en_o = (state_q == StWr) & ~rst_i;
  assign rsp_valid_o = (state_q == StResp) & ~rst_i;
  assign mem_addr_o  = addr_q[ADDR_W-1:2];
  assign mem_wdata_o = (state_q == StWr) ? st_word : '0;
  assign rsp_rdata_o = rsp_rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_err_o = (state_q == StResp) & ~rst_i & lsu_misaligned(size_q, addr_q[1:0]);
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: two instances (MEM_LAT 1 and 3), behavioural RAM and model.
module tb_lsu;
  import lsu_pkg::*;

  localparam int unsigned AW = byte_addr_p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] last_rdata;

  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  t_lsu_size     req_size  [2];
  logic          req_uns   [2];
  logic [AW-1:0] req_addr  [2];
  logic [31:0]   req_wdata [2];
  logic          rsp_valid [2];
  logic [31:0]   rsp_rdata [2];
  logic          rsp_err   [2];
  logic [AW-3:0] mem_addr  [2];
  logic          mem_rd    [2];
  logic          mem_wr    [2];
  logic [31:0]   mem_wdata [2];
  logic [31:0]   mem_rdata [2];

  logic [31:0] ram   [2][1024];
  logic [31:0] model [2][1024];
  logic [31:0] pipe  [2][3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lsu #(
      .ADDR_W  (AW),
      .MEM_LAT ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid[g]),
      .req_ready_o    (req_ready[g]),
      .req_we_i       (req_we[g]),
      .req_size_i     (req_size[g]),
      .req_unsigned_i (req_uns[g]),
      .req_addr_i     (req_addr[g]),
      .req_wdata_i    (req_wdata[g]),
      .rsp_valid_o    (rsp_valid[g]),
      .rsp_rdata_o    (rsp_rdata[g]),
      .rsp_err_o      (rsp_err[g]),
      .mem_addr_o     (mem_addr[g]),
      .mem_rd_en_o    (mem_rd[g]),
      .mem_wr_en_o    (mem_wr[g]),
      .mem_wdata_o    (mem_wdata[g]),
      .mem_rdata_i    (mem_rdata[g])
    );
  end

  // RAM: read data appears MEM_LAT cycles after the strobe, garbage otherwise
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_wr[k]) ram[k][mem_addr[k]] <= mem_wdata[k];
      pipe[k][0] <= mem_rd[k] ? ram[k][mem_addr[k]] : $urandom;
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble(input int k);
    req_we[k]    = 1'($urandom);
    req_size[k]  = t_lsu_size'(2'($urandom_range(0, 2)));
    req_uns[k]   = 1'($urandom);
    req_addr[k]  = AW'($urandom);
    req_wdata[k] = $urandom;
  endtask

  task automatic run_req(input int k, input logic we, input t_lsu_size sz, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wd, input string tag);
    int          lat, nrd, nwr, exp_lat, exp_nrd, exp_nwr, waited, t_acc, t_rsp, off;
    logic [31:0] old, exp_rd, exp_wword, mask, v, got_rd, wr_word;
    logic [AW-3:0] wr_addr;
    logic        exp_err, got_err, mis, trap;
    int unsigned wi;
    string       t;
    t   = $sformatf("%s/k%0d", tag, k);
    lat = (k == 0) ? 1 : 3;
    wi  = 32'(addr >> 2);
    old = model[k][wi];
    mis = ((sz == LSU_H) && addr[0]) || ((sz == LSU_W) && (addr[1:0] != 2'b00));
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis;
`endif
    off  = (sz == LSU_B) ? int'(addr % 4) : (sz == LSU_H) ? int'(addr & 2) : 0;
    mask = (sz == LSU_B) ? 32'hFF : (sz == LSU_H) ? 32'hFFFF : 32'hFFFF_FFFF;
    v = (old >> (8 * off)) & mask;
    if (!uns && sz == LSU_B && v >= 32'h80) v = v | 32'hFFFF_FF00;
    if (!uns && sz == LSU_H && v >= 32'h8000) v = v | 32'hFFFF_0000;
    exp_wword = (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    exp_err = 1'b0;
    exp_rd  = 32'h0;
    if (trap) begin
      exp_lat = 1; exp_nrd = 0; exp_nwr = 0; exp_err = 1'b1;
    end else if (!we) begin
      exp_lat = lat + 2; exp_nrd = 1; exp_nwr = 0; exp_rd = v;
    end else if (sz == LSU_W) begin
      exp_lat = 2; exp_nrd = 0; exp_nwr = 1;
    end else begin
      exp_lat = lat + 3; exp_nrd = 1; exp_nwr = 1;
    end

    @(negedge clk);
    req_valid[k] = 1'b1; req_we[k] = we; req_size[k] = sz; req_uns[k] = uns;
    req_addr[k] = addr; req_wdata[k] = wd;
    waited = 0;
    while (!req_ready[k] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({t, " ready"}, 32'(req_ready[k]), 32'd1);
    t_acc = cyc;
    @(negedge clk);
    req_valid[k] = 1'b0;
    scramble(k);
    nrd = 0; nwr = 0; t_rsp = -1; got_rd = 'x; got_err = 1'bx; wr_word = 'x; wr_addr = 'x;
    for (int i = 0; i < 12 && t_rsp < 0; i++) begin
      if (mem_rd[k]) begin
        nrd++;
        chk({t, " rd_addr"}, 32'(mem_addr[k]), wi);
      end
      if (mem_wr[k]) begin
        nwr++; wr_word = mem_wdata[k]; wr_addr = mem_addr[k];
      end
      if (rsp_valid[k]) begin
        t_rsp = cyc; got_rd = rsp_rdata[k]; got_err = rsp_err[k];
      end else begin
        @(negedge clk);
      end
    end
    chk({t, " latency"}, 32'(t_rsp - t_acc), 32'(exp_lat));
    chk({t, " rdata"}, got_rd, exp_rd);
    chk({t, " err"}, 32'(got_err), 32'(exp_err));
    chk({t, " n_rd"}, 32'(nrd), 32'(exp_nrd));
    chk({t, " n_wr"}, 32'(nwr), 32'(exp_nwr));
    if (exp_nwr == 1) begin
      chk({t, " wr_word"}, wr_word, exp_wword);
      chk({t, " wr_addr"}, 32'(wr_addr), wi);
      model[k][wi] = exp_wword;
    end
    last_rdata = got_rd;
    @(negedge clk);
    chk({t, " rsp_pulse"}, 32'(rsp_valid[k]), 32'd0);
    chk({t, " rdata_held"}, rsp_rdata[k], exp_rd);
    chk({t, " ram"}, ram[k][wi], model[k][wi]);
  endtask

  initial begin
    int nwr, nrsp;
    logic [31:0] saved;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      scramble(k);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(req_ready[0]), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst mem_wr", 32'(mem_wr[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst ready", 32'(req_ready[0]), 32'd1);
    chk("post-rst rdata", rsp_rdata[0], 32'd0);
    chk("post-rst mem_addr", 32'(mem_addr[0]), 32'd0);

    // Directed sequence around word 0x010
    for (int k = 0; k < 2; k++) run_req(k, 1'b1, LSU_W, 1'b0, 12'h040, 32'h8899_AABB, "sw_preset");
    run_req(0, 1'b0, LSU_B, 1'b0, 12'h041, 32'h0, "lb");
    chk("lb const", last_rdata, 32'hFFFF_FFAA);
    run_req(0, 1'b0, LSU_B, 1'b1, 12'h041, 32'h0, "lbu");
    chk("lbu const", last_rdata, 32'h0000_00AA);
    run_req(0, 1'b0, LSU_H, 1'b0, 12'h042, 32'h0, "lh");
    chk("lh const", last_rdata, 32'hFFFF_8899);
    run_req(0, 1'b0, LSU_H, 1'b1, 12'h042, 32'h0, "lhu");
    chk("lhu const", last_rdata, 32'h0000_8899);
    run_req(0, 1'b0, LSU_W, 1'b0, 12'h040, 32'h0, "lw");
    chk("lw const", last_rdata, 32'h8899_AABB);
    run_req(0, 1'b1, LSU_B, 1'b0, 12'h043, 32'h1234_5677, "sb");
    chk("sb const", ram[0][16], 32'h7799_AABB);
    run_req(0, 1'b1, LSU_H, 1'b0, 12'h040, 32'h0000_CAFE, "sh");
    chk("sh const", ram[0][16], 32'h7799_CAFE);
    run_req(0, 1'b1, LSU_W, 1'b0, 12'h040, 32'hDEAD_BEEF, "sw");
    run_req(1, 1'b0, LSU_W, 1'b0, 12'h040, 32'h0, "lw_lat3");
    run_req(1, 1'b1, LSU_B, 1'b0, 12'h041, 32'h0000_0055, "sb_lat3");
    run_req(0, 1'b0, LSU_W, 1'b0, 12'h042, 32'h0, "lw_misaligned");
    run_req(0, 1'b1, LSU_H, 1'b0, 12'h041, 32'h0000_1357, "sh_misaligned");

    // Reset during WAIT of a sub-word store
    saved = ram[0][16];
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = LSU_B; req_uns[0] = 1'b0;
    req_addr[0] = 12'h042; req_wdata[0] = 32'h0000_00EE;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nwr = 0; nrsp = 0;
    if (mem_wr[0]) nwr++;
    if (rsp_valid[0]) nrsp++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort ready", 32'(req_ready[0]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_wr[0]) nwr++;
      if (rsp_valid[0]) nrsp++;
    end
    chk("abort no write", 32'(nwr), 32'd0);
    chk("abort no rsp", 32'(nrsp), 32'd0);
    chk("abort ram", ram[0][16], saved);

    // Random traffic over 16 words per instance
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) run_req(k, 1'b1, LSU_W, 1'b0, AW'(w * 4), $urandom, "init");
      for (int n = 0; n < 40; n++) begin
        run_req(k, 1'($urandom), t_lsu_size'(2'($urandom_range(0, 2))), 1'($urandom),
                AW'($urandom_range(0, 63)), $urandom, $sformatf("rnd%0d", n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
